// File: rtl/medfilter_frame_writer.sv
// Median-filter output sink: packs pixels into 32-bit words, buffers them, and writes them out over an Avalon-MM-style master.
// Optional checksum output enabled by defining WRITER_CHECKSUM_EN.
module medfilter_frame_writer #(
  parameter int unsigned IMG_W      = 512,
  parameter int unsigned IMG_H      = 512,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Frame_start,
  output logic              Start_sig,
  input  logic              Done_sig,
  input  logic [7:0]        Data_in,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              wr_en,
  input  logic              wr_wait,
  output logic              frame_done,
  output logic              overflow
`ifdef WRITER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int unsigned TOTAL = IMG_W * IMG_H;
  localparam int unsigned PW    = $clog2(TOTAL + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  logic [PW-1:0]       r_pix_cnt;
  logic [1:0]          r_lane;
  logic [31:0]         r_word;
  logic [31:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;
  logic [ADDR_W-3:0]   r_word_idx;
  logic                r_start;
  logic                r_done;
  logic                r_ovf;
`ifdef WRITER_CHECKSUM_EN
  logic [15:0]         r_csum;
`endif

  logic        w_accept;
  logic        w_last;
  logic        w_push_req;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_nonempty;
  logic [31:0] w_packed;

  assign w_accept   = (r_state == S_RUN) && Done_sig;
  assign w_last     = (r_pix_cnt == PW'(TOTAL - 1));
  // Lanes above the current one are still zero, so OR-ing in the new byte also zero-pads a final partial word.
  assign w_packed   = r_word | ({24'd0, Data_in} << {r_lane, 3'd0});
  assign w_push_req = w_accept && ((r_lane == 2'd3) || w_last);
  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_push     = w_push_req && !w_full;
  assign w_pop      = w_nonempty && !wr_wait;

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_packed;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= S_IDLE;
      r_pix_cnt  <= '0;
      r_lane     <= '0;
      r_word     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_word_idx <= '0;
      r_start    <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
`ifdef WRITER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_word_idx <= r_word_idx + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (Frame_start) begin
            r_pix_cnt  <= '0;
            r_lane     <= '0;
            r_word     <= '0;
            r_word_idx <= '0;
            r_ovf      <= 1'b0;
            r_start    <= 1'b1;
`ifdef WRITER_CHECKSUM_EN
            r_csum     <= '0;
`endif
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
            r_lane    <= r_lane + 1'b1;
            r_word    <= w_push_req ? '0 : w_packed;
`ifdef WRITER_CHECKSUM_EN
            r_csum    <= r_csum + {8'd0, Data_in};
`endif
            if (w_push_req && w_full) r_ovf <= 1'b1;
            if (w_last) begin
              r_start <= 1'b0;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!w_nonempty) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Start_sig  = r_start;
  assign frame_done = r_done;
  assign overflow   = r_ovf;
  assign wr_en      = w_nonempty;
  assign wr_data    = w_nonempty ? r_mem[r_rd_ptr] : '0;
  assign wr_addr    = ADDR_W'(BASE_ADDR) + {r_word_idx, 2'b00};
`ifdef WRITER_CHECKSUM_EN
  assign checksum   = r_csum;
`endif

endmodule

// File: tb/tb_medfilter_frame_writer.sv
// Directed bench for medfilter_frame_writer: three differently sized instances share clock, reset and pixel stimulus.
module tb_medfilter_frame_writer;

  logic CLK;
  logic RSTn;
  logic done_sig;
  logic [7:0] data_in;
  logic wr_wait;
  logic fs_a, fs_b, fs_c;
  logic st_a, st_b, st_c;
  logic en_a, en_b, en_c;
  logic fd_a, fd_b, fd_c;
  logic ovf_a, ovf_b, ovf_c;
  logic [31:0] addr_a, addr_b, addr_c;
  logic [31:0] data_a, data_b, data_c;
`ifdef WRITER_CHECKSUM_EN
  logic [15:0] csum_a, csum_b, csum_c;
`endif

  int n_total;
  int n_bad;
  int fda, fdb, fdc;
  logic [31:0] qa_addr[$], qa_data[$];
  logic [31:0] qb_addr[$], qb_data[$];
  logic [31:0] qc_addr[$], qc_data[$];

  medfilter_frame_writer #(.IMG_W(4), .IMG_H(2), .FIFO_DEPTH(8), .BASE_ADDR(0), .ADDR_W(32)) u_a (
    .CLK(CLK), .RSTn(RSTn), .Frame_start(fs_a), .Start_sig(st_a), .Done_sig(done_sig),
    .Data_in(data_in), .wr_addr(addr_a), .wr_data(data_a), .wr_en(en_a), .wr_wait(wr_wait),
    .frame_done(fd_a), .overflow(ovf_a)
`ifdef WRITER_CHECKSUM_EN
    , .checksum(csum_a)
`endif
  );

  medfilter_frame_writer #(.IMG_W(16), .IMG_H(1), .FIFO_DEPTH(2), .BASE_ADDR(0), .ADDR_W(32)) u_b (
    .CLK(CLK), .RSTn(RSTn), .Frame_start(fs_b), .Start_sig(st_b), .Done_sig(done_sig),
    .Data_in(data_in), .wr_addr(addr_b), .wr_data(data_b), .wr_en(en_b), .wr_wait(wr_wait),
    .frame_done(fd_b), .overflow(ovf_b)
`ifdef WRITER_CHECKSUM_EN
    , .checksum(csum_b)
`endif
  );

  medfilter_frame_writer #(.IMG_W(3), .IMG_H(1), .FIFO_DEPTH(8), .BASE_ADDR(0), .ADDR_W(32)) u_c (
    .CLK(CLK), .RSTn(RSTn), .Frame_start(fs_c), .Start_sig(st_c), .Done_sig(done_sig),
    .Data_in(data_in), .wr_addr(addr_c), .wr_data(data_c), .wr_en(en_c), .wr_wait(wr_wait),
    .frame_done(fd_c), .overflow(ovf_c)
`ifdef WRITER_CHECKSUM_EN
    , .checksum(csum_c)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change just after posedge, so at negedge wr_wait already holds the value the next edge sees.
  always @(negedge CLK) begin
    if (RSTn) begin
      if (en_a && !wr_wait) begin qa_addr.push_back(addr_a); qa_data.push_back(data_a); end
      if (en_b && !wr_wait) begin qb_addr.push_back(addr_b); qb_data.push_back(data_b); end
      if (en_c && !wr_wait) begin qc_addr.push_back(addr_c); qc_data.push_back(data_c); end
      if (fd_a) fda++;
      if (fd_b) fdb++;
      if (fd_c) fdc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start(input int id);
    case (id)
      0:       fs_a = 1'b1;
      1:       fs_b = 1'b1;
      default: fs_c = 1'b1;
    endcase
    tick();
    fs_a = 1'b0;
    fs_b = 1'b0;
    fs_c = 1'b0;
  endtask

  task automatic feed(input logic [7:0] px);
    done_sig = 1'b1;
    data_in  = px;
    tick();
  endtask

  int sa, sb, sc, fa, fb, fc;

  initial begin
    n_total = 0; n_bad = 0;
    fda = 0; fdb = 0; fdc = 0;
    RSTn = 1'b0; done_sig = 1'b0; data_in = '0; wr_wait = 1'b0;
    fs_a = 1'b0; fs_b = 1'b0; fs_c = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;
    tick();

    check("rst_start", st_a, 0);
    check("rst_wr_en", en_a, 0);
    check("rst_frame_done", fd_a, 0);
    check("rst_overflow", ovf_a, 0);
    check("rst_wr_data", data_a, 0);
    check("rst_wr_addr", addr_a, 0);

    // Basic 4x2 frame
    sa = qa_addr.size(); fa = fda;
    pulse_start(0);
    check("basic_start_rise", st_a, 1);
    for (int i = 1; i <= 8; i++) begin
      feed(8'(i));
      if (i == 7) check("basic_start_held", st_a, 1);
    end
    done_sig = 1'b0;
    check("basic_start_fall", st_a, 0);
    repeat (20) tick();
    check("basic_nwrites", qa_addr.size() - sa, 2);
    check("basic_fd_pulses", fda - fa, 1);
    if (qa_addr.size() >= sa + 2) begin
      check("basic_addr0", qa_addr[sa], 32'h0);
      check("basic_data0", qa_data[sa], 32'h04030201);
      check("basic_addr1", qa_addr[sa+1], 32'h4);
      check("basic_data1", qa_data[sa+1], 32'h08070605);
    end

    // Backpressure on the first write
    wr_wait = 1'b1;
    sa = qa_addr.size(); fa = fda;
    pulse_start(0);
    for (int i = 1; i <= 8; i++) feed(8'(i));
    done_sig = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_wr_en", en_a, 1);
      check("bp_addr_hold", addr_a, 32'h0);
      check("bp_data_hold", data_a, 32'h04030201);
      tick();
    end
    check("bp_no_early_write", qa_addr.size() - sa, 0);
    wr_wait = 1'b0;
    repeat (20) tick();
    check("bp_nwrites", qa_addr.size() - sa, 2);
    if (qa_addr.size() >= sa + 2) begin
      check("bp_addr0", qa_addr[sa], 32'h0);
      check("bp_data0", qa_data[sa], 32'h04030201);
      check("bp_addr1", qa_addr[sa+1], 32'h4);
      check("bp_data1", qa_data[sa+1], 32'h08070605);
    end
    check("bp_overflow", ovf_a, 0);
    check("bp_fd_pulses", fda - fa, 1);

    // Overflow: depth-2 FIFO, 16 pixels, slave stalled
    wr_wait = 1'b1;
    sb = qb_addr.size(); fb = fdb;
    pulse_start(1);
    for (int i = 1; i <= 16; i++) begin
      feed(8'(i));
      if (i == 8)  check("ovf_after_word2", ovf_b, 0);
      if (i == 12) check("ovf_after_word3", ovf_b, 1);
    end
    done_sig = 1'b0;
    repeat (3) tick();
    check("ovf_no_fd_while_stalled", fdb - fb, 0);
    wr_wait = 1'b0;
    repeat (20) tick();
    check("ovf_nwrites", qb_addr.size() - sb, 2);
    if (qb_addr.size() >= sb + 2) begin
      check("ovf_data0", qb_data[sb], 32'h04030201);
      check("ovf_addr1", qb_addr[sb+1], 32'h4);
      check("ovf_data1", qb_data[sb+1], 32'h08070605);
    end
    check("ovf_fd_pulses", fdb - fb, 1);
    check("ovf_sticky", ovf_b, 1);

    // Partial final word
    sc = qc_addr.size(); fc = fdc;
    pulse_start(2);
    feed(8'hAA); feed(8'hBB); feed(8'hCC);
    done_sig = 1'b0;
    repeat (20) tick();
    check("part_nwrites", qc_addr.size() - sc, 1);
    if (qc_addr.size() >= sc + 1) begin
      check("part_addr", qc_addr[sc], 32'h0);
      check("part_data", qc_data[sc], 32'h00CCBBAA);
    end
    check("part_fd_pulses", fdc - fc, 1);

    // Reset during the 5th pixel
    wr_wait = 1'b1;
    pulse_start(0);
    for (int i = 1; i <= 4; i++) feed(8'(i));
    check("rstmid_wr_en_before", en_a, 1);
    done_sig = 1'b1;
    data_in  = 8'h05;
    #2 RSTn = 1'b0;
    #1;
    check("rstmid_start", st_a, 0);
    check("rstmid_wr_en", en_a, 0);
    check("rstmid_frame_done", fd_a, 0);
    tick();
    done_sig = 1'b0;
    wr_wait  = 1'b0;
    repeat (2) tick();
    RSTn = 1'b1;
    tick();
    sa = qa_addr.size(); fa = fda;
    pulse_start(0);
    for (int i = 0; i < 8; i++) feed(8'h11 + 8'(i));
    done_sig = 1'b0;
    repeat (20) tick();
    check("rstmid_nwrites", qa_addr.size() - sa, 2);
    if (qa_addr.size() >= sa + 2) begin
      check("rstmid_addr0", qa_addr[sa], 32'h0);
      check("rstmid_data0", qa_data[sa], 32'h14131211);
      check("rstmid_addr1", qa_addr[sa+1], 32'h4);
      check("rstmid_data1", qa_data[sa+1], 32'h18171615);
    end
    check("rstmid_fd_pulses", fda - fa, 1);

`ifdef WRITER_CHECKSUM_EN
    fa = fda;
    pulse_start(0);
    for (int i = 0; i < 8; i++) feed(8'hFF);
    done_sig = 1'b0;
    repeat (20) tick();
    check("csum_fd_pulses", fda - fa, 1);
    check("csum_value", csum_a, 32'h07F8);
    for (int i = 0; i < 3; i++) feed(8'h55);
    done_sig = 1'b0;
    tick();
    check("csum_idle_stable", csum_a, 32'h07F8);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
